main_control_nch: RTL and testbench

//  Parametrised successor to the correlator main control. Sequences N_CH input FIFOs into the

---
 rtl/main_control_nch_pkg.sv | 15 +
 rtl/main_control_nch_ctl_timeout_counter.sv | 37 +++
 rtl/main_control_nch.sv | 138 +++++++++++++
 tb/tb_main_control_nch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_control_nch_pkg.sv
// Shared definitions for the N-channel correlator main control.
// Holds the controller state encoding (IDLE=0 .. FAILURE=4, 3-bit).
package main_control_nch_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_COMPUTE   = 3'd3,
    ST_FAILURE   = 3'd4
  } state_t;

endpackage

// File: rtl/main_control_nch_ctl_timeout_counter.sv
// Watchdog counter for the correlator main control.
// Counts enabled cycles since the last clear and flags expiry when the
// count reaches limit-1. A limit of 0 disables the watchdog. The count
// saturates at all-ones so a long wait with the watchdog off never wraps.
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      synchronous active-high reset
//   clear   in  1      force count to 0 on the next edge (wins over enable)
//   enable  in  1      count this cycle
//   limit   in  TMO_W  timeout value, 0 = off
//   expired out 1      combinational: limit!=0 && count==limit-1
module ctl_timeout_counter #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expired = (limit != '0) && (cnt == (limit - TMO_W'(1)));

endmodule

// File: rtl/main_control_nch.sv
// Correlator main control for N_CH input FIFOs read in lock-step.
// Sequence: IDLE -> FLUSH (fifo_rst/clr held FLUSH_CYC cycles) ->
// WAIT_DATA <-> COMPUTE, ending on sample count, done or stop.
// A no-data watchdog in WAIT_DATA drives the sticky FAILURE state.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        begin a run (IDLE only)
//   stop         abort run / leave FAILURE
//   done         external end-of-run from the correlator
//   empty        per-channel FIFO empty flags
//   n_samples    reads per run, 0 = unlimited
//   tmo_cycles   max consecutive no-read cycles in WAIT_DATA, 0 = off
//   fifo_read    combinational read strobe to all FIFOs
//   fifo_rst/clr registered FIFO reset / datapath clear (high in FLUSH)
//   stall        registered ~fifo_read (data arrives one cycle after read)
//   failure      registered, high while in FAILURE
//   busy         any state other than IDLE
//   sample_cnt   reads issued in the current run
module main_control_nch
  import main_control_nch_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 32,
  parameter int TMO_W     = 16,
  parameter int FLUSH_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             done,
  input  logic [N_CH-1:0]  empty,
  input  logic [CNT_W-1:0] n_samples,
  input  logic [TMO_W-1:0] tmo_cycles,
  output logic             fifo_read,
  output logic             fifo_rst,
  output logic             clr,
  output logic             stall,
  output logic             failure,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_cnt;
  logic            all_ok;
  logic            last;
  logic            flush_done;
  logic            wd_clear;
  logic            wd_enable;
  logic            wd_expired;

  assign all_ok     = (empty == '0);
  assign last       = (n_samples != '0) && (sample_cnt == (n_samples - CNT_W'(1)));
  assign flush_done = (flush_cnt == FC_W'(FLUSH_CYC - 1));
  assign busy       = (state != ST_IDLE);

  // A read needs every FIFO non-empty; stop, or done while computing,
  // suppresses the read in the same cycle.
  assign fifo_read = ((state == ST_WAIT_DATA) || (state == ST_COMPUTE)) && all_ok &&
                     !stop && !((state == ST_COMPUTE) && done);

  // Holding the watchdog in clear outside WAIT_DATA guarantees a zero
  // count on every entry; any read also restarts it.
  assign wd_clear  = (state != ST_WAIT_DATA) || fifo_read;
  assign wd_enable = (state == ST_WAIT_DATA);

  ctl_timeout_counter #(
    .TMO_W(TMO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .limit  (tmo_cycles),
    .expired(wd_expired)
  );

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (stop)            state_nxt = ST_IDLE;
        else if (flush_done) state_nxt = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        // A read issued here can be the final one of the run after a
        // COMPUTE -> WAIT_DATA bounce, so honour last here as well.
        if (stop)            state_nxt = ST_IDLE;
        else if (all_ok)     state_nxt = last ? ST_IDLE : ST_COMPUTE;
        else if (wd_expired) state_nxt = ST_FAILURE;
      end
      ST_COMPUTE: begin
        if (stop || done)           state_nxt = ST_IDLE;
        else if (fifo_read && last) state_nxt = ST_IDLE;
        else if (!all_ok)           state_nxt = ST_WAIT_DATA;
      end
      ST_FAILURE: begin
        if (stop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      sample_cnt <= '0;
      fifo_rst   <= 1'b0;
      clr        <= 1'b0;
      stall      <= 1'b1;
      failure    <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Decoded from the next state so the flags line up with the state.
      fifo_rst <= (state_nxt == ST_FLUSH);
      clr      <= (state_nxt == ST_FLUSH);
      failure  <= (state_nxt == ST_FAILURE);
      stall    <= ~fifo_read;
      if ((state == ST_IDLE) && start) begin
        sample_cnt <= '0;
        flush_cnt  <= '0;
      end else begin
        if (fifo_read)          sample_cnt <= sample_cnt + CNT_W'(1);
        if (state == ST_FLUSH)  flush_cnt  <= flush_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_main_control_nch.sv
module tb_main_control_nch;

  localparam int FLUSH_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, done;
  logic [1:0]  empty;
  logic [31:0] n_samples;
  logic [15:0] tmo_cycles;
  logic        fifo_read, fifo_rst, clr, stall, failure, busy;
  logic [31:0] sample_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  main_control_nch #(
    .N_CH(2), .CNT_W(32), .TMO_W(16), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .done(done),
    .empty(empty), .n_samples(n_samples), .tmo_cycles(tmo_cycles),
    .fifo_read(fifo_read), .fifo_rst(fifo_rst), .clr(clr), .stall(stall),
    .failure(failure), .busy(busy), .sample_cnt(sample_cnt)
  );

  // Reference model: run phase, flush progress, consecutive idle waits,
  // reads this run, and whether the previous cycle issued a read.
  localparam int P_IDLE = 0, P_FLUSH = 1, P_WAIT = 2, P_COMP = 3, P_FAIL = 4;
  int          m_phase;
  int          m_flush;
  longint      m_wait;
  logic [31:0] m_cnt;
  bit          m_read_prev;

  function automatic bit m_read();
    return ((m_phase == P_WAIT) || (m_phase == P_COMP)) && (empty == 2'b00) &&
           !stop && !((m_phase == P_COMP) && done);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_flush = 0; m_wait = 0; m_cnt = '0; m_read_prev = 1'b0;
  endtask

  task automatic model_edge();
    bit rd, fin;
    if (rst) begin
      model_reset();
      return;
    end
    rd  = m_read();
    fin = rd && (n_samples != 0) && ((m_cnt + 32'd1) == n_samples);
    m_read_prev = rd;
    if (rd) m_cnt = m_cnt + 32'd1;
    case (m_phase)
      P_IDLE:  if (start) begin m_phase = P_FLUSH; m_flush = 0; m_cnt = '0; end
      P_FLUSH: begin
        if (stop) m_phase = P_IDLE;
        else if (m_flush + 1 == FLUSH_CYC) begin m_phase = P_WAIT; m_wait = 0; end
        else m_flush++;
      end
      P_WAIT: begin
        if (stop) m_phase = P_IDLE;
        else if (rd) m_phase = fin ? P_IDLE : P_COMP;
        else if ((tmo_cycles != 0) && (m_wait + 1 == longint'(tmo_cycles))) m_phase = P_FAIL;
        else m_wait++;
      end
      P_COMP: begin
        if (stop || done) m_phase = P_IDLE;
        else if (fin) m_phase = P_IDLE;
        else if (empty != 2'b00) begin m_phase = P_WAIT; m_wait = 0; end
      end
      default: if (stop) m_phase = P_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mid-cycle compare of every output against the model.
  task automatic settle();
    #4;
    check("fifo_read",  32'(fifo_read), 32'(m_read()));
    check("fifo_rst",   32'(fifo_rst),  32'(m_phase == P_FLUSH));
    check("clr",        32'(clr),       32'(m_phase == P_FLUSH));
    check("stall",      32'(stall),     32'(!m_read_prev));
    check("failure",    32'(failure),   32'(m_phase == P_FAIL));
    check("busy",       32'(busy),      32'(m_phase != P_IDLE));
    check("sample_cnt", sample_cnt,     m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  typedef struct {
    bit         start, stop, done;
    logic [1:0] empty;
    bit         exp_read, exp_busy, exp_rst;
    int         exp_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input bit s, input bit p, input bit d, input logic [1:0] e,
                         input bit r, input bit b, input bit f, input int c);
    vec_t v;
    v.start = s; v.stop = p; v.done = d; v.empty = e;
    v.exp_read = r; v.exp_busy = b; v.exp_rst = f; v.exp_cnt = c;
    tbl.push_back(v);
  endtask

  initial begin
    int reads, flushes, first_rd, last_rd, waits, guard;

    // Short run with n_samples=3, an empty bounce, stop in FLUSH,
    // stop in COMPUTE, and stop+done together.
    add_vec(1'b1,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 0);
    for (int i = 0; i < 4; i++) add_vec(1'b0,1'b0,1'b0,2'b00, 1'b0,1'b1,1'b1, 0);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b1,1'b1,1'b0, 0);
    add_vec(1'b0,1'b0,1'b0,2'b01, 1'b0,1'b1,1'b0, 1);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b1,1'b1,1'b0, 1);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b1,1'b1,1'b0, 2);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 3);
    add_vec(1'b1,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 3);
    add_vec(1'b0,1'b1,1'b0,2'b00, 1'b0,1'b1,1'b1, 0);
    add_vec(1'b1,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 0);
    for (int i = 0; i < 4; i++) add_vec(1'b0,1'b0,1'b0,2'b00, 1'b0,1'b1,1'b1, 0);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b1,1'b1,1'b0, 0);
    add_vec(1'b0,1'b1,1'b0,2'b00, 1'b0,1'b1,1'b0, 1);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1);
    add_vec(1'b1,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1);
    for (int i = 0; i < 4; i++) add_vec(1'b0,1'b0,1'b0,2'b00, 1'b0,1'b1,1'b1, 0);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b1,1'b1,1'b0, 0);
    add_vec(1'b0,1'b1,1'b1,2'b00, 1'b0,1'b1,1'b0, 1);
    add_vec(1'b0,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1);

    rst = 1'b1; start = 1'b0; stop = 1'b0; done = 1'b0; empty = 2'b00;
    n_samples = 32'd3; tmo_cycles = 16'd0;
    @(posedge clk); @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;

    // Reset state
    settle();
    check("reset_stall", 32'(stall), 32'd1);
    check("reset_busy",  32'(busy),  32'd0);
    tick();

    foreach (tbl[i]) begin
      start = tbl[i].start; stop = tbl[i].stop; done = tbl[i].done; empty = tbl[i].empty;
      settle();
      check($sformatf("tbl%0d_read", i), 32'(fifo_read), 32'(tbl[i].exp_read));
      check($sformatf("tbl%0d_busy", i), 32'(busy),      32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_rst",  i), 32'(fifo_rst),  32'(tbl[i].exp_rst));
      check($sformatf("tbl%0d_cnt",  i), sample_cnt,     32'(tbl[i].exp_cnt));
      tick();
    end
    start = 1'b0; stop = 1'b0; done = 1'b0;

    // 8 back-to-back reads after a 4-cycle flush
    n_samples = 32'd8; empty = 2'b00;
    start = 1'b1; cycle(); start = 1'b0;
    reads = 0; flushes = 0; first_rd = -1; last_rd = -1; guard = 0;
    while (busy && guard < 50) begin
      settle();
      if (fifo_rst) flushes++;
      if (fifo_read) begin
        if (first_rd < 0) first_rd = guard;
        last_rd = guard;
        reads++;
      end
      tick();
      guard++;
    end
    check("t1_timeout",  32'(guard < 50), 32'd1);
    check("t1_flush",    32'(flushes), 32'(FLUSH_CYC));
    check("t1_reads",    32'(reads), 32'd8);
    check("t1_b2b",      32'(last_rd - first_rd), 32'd7);
    settle();
    check("t1_cnt",      sample_cnt, 32'd8);
    check("t1_idle",     32'(busy), 32'd0);
    tick();

    // Watchdog: 10 idle cycles in WAIT_DATA then FAILURE
    tmo_cycles = 16'd10;
    start = 1'b1; cycle(); start = 1'b0;
    empty = 2'b11;
    waits = 0; guard = 0;
    while (!failure && guard < 60) begin
      settle();
      if (busy && !fifo_rst && !failure) waits++;
      tick();
      guard++;
    end
    check("t3_timeout", 32'(guard < 60), 32'd1);
    check("t3_waits",   32'(waits), 32'd10);
    start = 1'b1; cycle(); cycle(); start = 1'b0;
    settle();
    check("t3_sticky",  32'(failure), 32'd1);
    tick();
    stop = 1'b1; cycle(); stop = 1'b0;
    settle();
    check("t3_cleared", 32'(failure), 32'd0);
    check("t3_idle",    32'(busy), 32'd0);
    tick();

    // Unlimited run: 100 reads, then done ends it with no read
    n_samples = 32'd0; tmo_cycles = 16'd0; empty = 2'b00;
    start = 1'b1; cycle(); start = 1'b0;
    reads = 0; guard = 0;
    while (reads < 100 && guard < 200) begin
      settle();
      if (fifo_read) reads++;
      tick();
      guard++;
    end
    check("t4_timeout", 32'(guard < 200), 32'd1);
    done = 1'b1;
    settle();
    check("t4_no_read_on_done", 32'(fifo_read), 32'd0);
    tick();
    done = 1'b0;
    settle();
    check("t4_cnt",  sample_cnt, 32'd100);
    check("t4_idle", 32'(busy), 32'd0);
    tick();

    // Reset in the middle of COMPUTE
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    settle();
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_stall", 32'(stall), 32'd1);
    check("t6_rst_cnt",   sample_cnt, 32'd0);
    check("t6_rst_frst",  32'(fifo_rst), 32'd0);
    tick();

    // Watchdog off: wait beyond 2^16 cycles without failing
    tmo_cycles = 16'd0; empty = 2'b11;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 66000; i++) cycle();
    settle();
    check("t6_no_fail", 32'(failure), 32'd0);
    check("t6_waiting", 32'(busy), 32'd1);
    tick();
    stop = 1'b1; cycle(); stop = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      done  = ($urandom_range(0, 39) == 0);
      empty = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      if (!busy && start) begin
        n_samples  = 32'($urandom_range(0, 12));
        tmo_cycles = 16'($urandom_range(0, 15));
      end
      cycle();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
